// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-word bit positions and the ID/EX payload type for the
// ID->EX pipeline register and its hazard logic.
package id_ex_stage_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;

  // Control word layout: {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_REGDST   = 2;
  localparam int unsigned CTRL_ALUOP    = 0;
  localparam int unsigned CTRL_ALUOP_W  = 2;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    logic     valid;
    ctrl_t    ctrl;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
    data_t    data1;
    data_t    data2;
    data_t    imm;
  } id_ex_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } ctrl_state_e;

  // An invalid instruction never carries live control bits downstream.
  function automatic ctrl_t ctrl_qualify(input logic valid, input ctrl_t ctrl);
    return valid ? ctrl : CTRL_W'(0);
  endfunction

  function automatic logic ctrl_is_load(input ctrl_t ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// instruction currently decoded in ID.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic [CTRL_W-1:0] ex_ctrl_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             load_use_o
);

  logic ex_load;
  logic rs_hit;
  logic rt_hit;

  // A load targeting r0 produces nothing worth waiting for.
  assign ex_load    = ex_valid_i & ctrl_is_load(ex_ctrl_i) & (ex_rt_i != REG_W'(0));
  assign rs_hit     = (ex_rt_i == id_rs_i);
  assign rt_hit     = id_uses_rt_i & (ex_rt_i == id_rt_i);
  assign load_use_o = ex_load & id_valid_i & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold, branch flush (including flush deferred
// across a hold), load-use bubble insertion and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Hold_i,
  input  logic              Flush_i,
  input  logic              IDValid_i,
  input  logic [REG_W-1:0]  IDRegRs_i,
  input  logic [REG_W-1:0]  IDRegRt_i,
  input  logic [REG_W-1:0]  IDRegRd_i,
  input  logic              IDUsesRt_i,
  input  logic [DATA_W-1:0] IDData1_i,
  input  logic [DATA_W-1:0] IDData2_i,
  input  logic [DATA_W-1:0] IDImm_i,
  input  logic [CTRL_W-1:0] IDCtrl_i,
  output logic [REG_W-1:0]  EXRegRs_o,
  output logic [REG_W-1:0]  EXRegRt_o,
  output logic [REG_W-1:0]  EXRegRd_o,
  output logic [DATA_W-1:0] EXData1_o,
  output logic [DATA_W-1:0] EXData2_o,
  output logic [DATA_W-1:0] EXImm_o,
  output logic [CTRL_W-1:0] EXCtrl_o,
  output logic              EXValid_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic [CNT_W-1:0]  BubbleCnt_o
);

  id_ex_t       ex_q, ex_d;
  id_ex_t       id_pkt;
  ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         load_use;
  logic         flush_now;

  load_use_detect u_load_use_detect (
    .ex_valid_i   (ex_q.valid),
    .ex_ctrl_i    (ex_q.ctrl),
    .ex_rt_i      (ex_q.rt),
    .id_valid_i   (IDValid_i),
    .id_rs_i      (IDRegRs_i),
    .id_rt_i      (IDRegRt_i),
    .id_uses_rt_i (IDUsesRt_i),
    .load_use_o   (load_use)
  );

  always_comb begin
    id_pkt       = '0;
    id_pkt.valid = IDValid_i;
    id_pkt.ctrl  = ctrl_qualify(IDValid_i, IDCtrl_i);
    id_pkt.rs    = IDRegRs_i;
    id_pkt.rt    = IDRegRt_i;
    id_pkt.rd    = IDRegRd_i;
    id_pkt.data1 = IDData1_i;
    id_pkt.data2 = IDData2_i;
    id_pkt.imm   = IDImm_i;
  end

  // A flush seen during a hold is remembered and applied on the first free edge.
  assign flush_now = Flush_i | (state_q == ST_PEND);

  // Edge priority: hold, then flush (live or pending), then load-use, then load.
  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Hold_i) begin
      if (Flush_i) begin
        state_d = ST_PEND;
      end
    end else if (flush_now) begin
      ex_d    = '0;
      state_d = ST_RUN;
    end else if (load_use) begin
      ex_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EXRegRs_o   = ex_q.rs;
  assign EXRegRt_o   = ex_q.rt;
  assign EXRegRd_o   = ex_q.rd;
  assign EXData1_o   = ex_q.data1;
  assign EXData2_o   = ex_q.data2;
  assign EXImm_o     = ex_q.imm;
  assign EXCtrl_o    = ex_q.ctrl;
  assign EXValid_o   = ex_q.valid;
  assign BubbleCnt_o = cnt_q;

  // Upstream stall is same-cycle so IF/ID never advance past a held or hazarded slot.
  assign PCWrite_o   = ~(Hold_i | load_use);
  assign IFIDWrite_o = ~(Hold_i | load_use);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: default-width instance plus a
// CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        hold, flush, id_valid, uses_rt;
  logic [4:0]  rs, rt, rd;
  logic [31:0] d1, d2, imm;
  logic [7:0]  ctrl;

  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_d1, ex_d2, ex_imm;
  logic [7:0]  ex_ctrl;
  logic        ex_valid, pcw, ifidw;
  logic [15:0] cnt;

  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_d1, s_d2, s_imm;
  logic [7:0]  s_ctrl;
  logic        s_valid, s_pcw, s_ifidw;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_n), .Hold_i(hold), .Flush_i(flush), .IDValid_i(id_valid),
    .IDRegRs_i(rs), .IDRegRt_i(rt), .IDRegRd_i(rd), .IDUsesRt_i(uses_rt),
    .IDData1_i(d1), .IDData2_i(d2), .IDImm_i(imm), .IDCtrl_i(ctrl),
    .EXRegRs_o(ex_rs), .EXRegRt_o(ex_rt), .EXRegRd_o(ex_rd),
    .EXData1_o(ex_d1), .EXData2_o(ex_d2), .EXImm_o(ex_imm), .EXCtrl_o(ex_ctrl),
    .EXValid_o(ex_valid), .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .BubbleCnt_o(cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .Hold_i(hold), .Flush_i(flush), .IDValid_i(id_valid),
    .IDRegRs_i(rs), .IDRegRt_i(rt), .IDRegRd_i(rd), .IDUsesRt_i(uses_rt),
    .IDData1_i(d1), .IDData2_i(d2), .IDImm_i(imm), .IDCtrl_i(ctrl),
    .EXRegRs_o(s_rs), .EXRegRt_o(s_rt), .EXRegRd_o(s_rd),
    .EXData1_o(s_d1), .EXData2_o(s_d2), .EXImm_o(s_imm), .EXCtrl_o(s_ctrl),
    .EXValid_o(s_valid), .PCWrite_o(s_pcw), .IFIDWrite_o(s_ifidw), .BubbleCnt_o(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        hold, flush, valid, uses_rt;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1;
    logic [7:0]  ctrl;
    logic        e_pcw, e_valid, chk_data;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [31:0] e_d1;
    logic [7:0]  e_ctrl;
    int          e_cnt, e_sat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int h, f, v, u, r_s, r_t, r_d, dat, c,
                              input int epcw, ev, cd, ers, ert, erd, ed1, ectrl, ecnt, esat);
    vec_t t;
    t.hold = 1'(h);   t.flush = 1'(f);  t.valid = 1'(v);  t.uses_rt = 1'(u);
    t.rs = 5'(r_s);   t.rt = 5'(r_t);   t.rd = 5'(r_d);
    t.d1 = 32'(dat);  t.ctrl = 8'(c);
    t.e_pcw = 1'(epcw); t.e_valid = 1'(ev); t.chk_data = 1'(cd);
    t.e_rs = 5'(ers); t.e_rt = 5'(ert); t.e_rd = 5'(erd);
    t.e_d1 = 32'(ed1); t.e_ctrl = 8'(ectrl);
    t.e_cnt = ecnt;   t.e_sat = esat;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector, check the same-cycle stall, then the registered result.
  task automatic apply(input vec_t t, input string tag);
    hold = t.hold; flush = t.flush; id_valid = t.valid; uses_rt = t.uses_rt;
    rs = t.rs; rt = t.rt; rd = t.rd; ctrl = t.ctrl;
    d1 = t.d1; d2 = t.d1 + 32'h100; imm = t.d1 + 32'h200;
    #1;
    check({tag, " PCWrite"},   32'(pcw),   32'(t.e_pcw));
    check({tag, " IFIDWrite"}, 32'(ifidw), 32'(t.e_pcw));
    @(posedge clk);
    #1;
    check({tag, " EXValid"}, 32'(ex_valid), 32'(t.e_valid));
    check({tag, " EXRegRs"}, 32'(ex_rs),    32'(t.e_rs));
    check({tag, " EXRegRt"}, 32'(ex_rt),    32'(t.e_rt));
    check({tag, " EXRegRd"}, 32'(ex_rd),    32'(t.e_rd));
    check({tag, " EXCtrl"},  32'(ex_ctrl),  32'(t.e_ctrl));
    check({tag, " BubbleCnt"},     32'(cnt),   32'(t.e_cnt));
    check({tag, " BubbleCnt_sat"}, 32'(s_cnt), 32'(t.e_sat));
    if (t.chk_data) begin
      check({tag, " EXData1"}, ex_d1,  t.e_d1);
      check({tag, " EXData2"}, ex_d2,  t.e_d1 + 32'h100);
      check({tag, " EXImm"},   ex_imm, t.e_d1 + 32'h200);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " EXValid"}, 32'(ex_valid), 32'h0);
    check({tag, " EXRegRs"}, 32'(ex_rs), 32'h0);
    check({tag, " EXRegRt"}, 32'(ex_rt), 32'h0);
    check({tag, " EXRegRd"}, 32'(ex_rd), 32'h0);
    check({tag, " EXData1"}, ex_d1, 32'h0);
    check({tag, " EXData2"}, ex_d2, 32'h0);
    check({tag, " EXImm"},   ex_imm, 32'h0);
    check({tag, " EXCtrl"},  32'(ex_ctrl), 32'h0);
    check({tag, " BubbleCnt"},     32'(cnt), 32'h0);
    check({tag, " BubbleCnt_sat"}, 32'(s_cnt), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b0; uses_rt = 1'b0;
    rs = '0; rt = '0; rd = '0; d1 = '0; d2 = '0; imm = '0; ctrl = '0;

    //        h f v u  rs rt rd  d1    ctrl  | pcw v cd ers ert erd ed1  ectrl cnt sat
    tbl.push_back(mk(0,0,1,1,  3, 4, 7, 'h11, 'h81,  1,1,1,  3, 4, 7, 'h11, 'h81, 0,0));
    tbl.push_back(mk(0,0,1,0,  1, 5, 0, 'h0A, 'hE8,  1,1,1,  1, 5, 0, 'h0A, 'hE8, 0,0));
    tbl.push_back(mk(0,0,1,1,  5, 6, 2, 'h55, 'h82,  0,0,0,  0, 0, 0, 0,    0,    1,1));
    tbl.push_back(mk(0,0,1,1,  5, 6, 2, 'h55, 'h82,  1,1,1,  5, 6, 2, 'h55, 'h82, 1,1));
    tbl.push_back(mk(0,0,0,1,  9,10,11, 'h99, 'hFF,  1,0,1,  9,10,11, 'h99, 0,    1,1));
    tbl.push_back(mk(0,0,1,0,  0, 0, 0, 'h01, 'hE8,  1,1,1,  0, 0, 0, 'h01, 'hE8, 1,1));
    tbl.push_back(mk(0,0,1,1,  0, 0, 3, 'h02, 'h81,  1,1,1,  0, 0, 3, 'h02, 'h81, 1,1));
    tbl.push_back(mk(0,0,1,0,  2, 7, 0, 'h03, 'hE8,  1,1,1,  2, 7, 0, 'h03, 'hE8, 1,1));
    tbl.push_back(mk(0,0,1,0,  1, 7, 4, 'h04, 'h81,  1,1,1,  1, 7, 4, 'h04, 'h81, 1,1));
    tbl.push_back(mk(0,0,1,0,  2, 8, 0, 'h05, 'hE8,  1,1,1,  2, 8, 0, 'h05, 'hE8, 1,1));
    tbl.push_back(mk(0,0,1,1,  1, 8, 4, 'h06, 'h81,  0,0,0,  0, 0, 0, 0,    0,    2,2));
    tbl.push_back(mk(0,0,1,0,  3, 9, 0, 'h07, 'hE8,  1,1,1,  3, 9, 0, 'h07, 'hE8, 2,2));
    tbl.push_back(mk(0,0,0,1,  9, 0, 0, 'h08, 'h81,  1,0,1,  9, 0, 0, 'h08, 0,    2,2));
    tbl.push_back(mk(0,0,1,1,  4, 5, 6, 'h09, 'h81,  1,1,1,  4, 5, 6, 'h09, 'h81, 2,2));
    tbl.push_back(mk(0,1,1,1,  7, 1, 2, 'h0B, 'h81,  1,0,0,  0, 0, 0, 0,    0,    2,2));
    tbl.push_back(mk(0,0,1,0,  1,10, 0, 'h0A, 'hE8,  1,1,1,  1,10, 0, 'h0A, 'hE8, 2,2));
    tbl.push_back(mk(0,1,1,1, 10, 3, 4, 'h0C, 'h81,  0,0,0,  0, 0, 0, 0,    0,    2,2));
    tbl.push_back(mk(0,0,1,1, 12,13,14, 'h0D, 'h81,  1,1,1, 12,13,14, 'h0D, 'h81, 2,2));
    tbl.push_back(mk(1,0,1,1,  1, 2, 3, 'h0E, 'h82,  0,1,1, 12,13,14, 'h0D, 'h81, 2,2));
    tbl.push_back(mk(0,0,1,0,  1,11, 0, 'h0F, 'hE8,  1,1,1,  1,11, 0, 'h0F, 'hE8, 2,2));
    tbl.push_back(mk(1,0,1,0, 11, 0, 1, 'h10, 'h81,  0,1,1,  1,11, 0, 'h0F, 'hE8, 2,2));
    tbl.push_back(mk(0,0,1,0, 11, 0, 1, 'h10, 'h81,  0,0,0,  0, 0, 0, 0,    0,    3,3));
    tbl.push_back(mk(0,0,1,0, 11, 0, 1, 'h10, 'h81,  1,1,1, 11, 0, 1, 'h10, 'h81, 3,3));
    // flush under a three-cycle hold, released with flush already low
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,1,1,1, 20,21,22, 'h20, 'h82,  0,1,1, 11, 0, 1, 'h10, 'h81, 3,3));
    tbl.push_back(mk(0,0,1,1, 20,21,22, 'h20, 'h82,  1,0,0,  0, 0, 0, 0,    0,    3,3));
    tbl.push_back(mk(0,0,1,1, 20,21,22, 'h20, 'h82,  1,1,1, 20,21,22, 'h20, 'h82, 3,3));
    // two more load-use events: narrow counter stays at 3
    tbl.push_back(mk(0,0,1,0,  1,12, 0, 'h30, 'hE8,  1,1,1,  1,12, 0, 'h30, 'hE8, 3,3));
    tbl.push_back(mk(0,0,1,0, 12, 0, 5, 'h31, 'h81,  0,0,0,  0, 0, 0, 0,    0,    4,3));
    tbl.push_back(mk(0,0,1,0, 12, 0, 5, 'h31, 'h81,  1,1,1, 12, 0, 5, 'h31, 'h81, 4,3));
    tbl.push_back(mk(0,0,1,0,  1,13, 0, 'h32, 'hE8,  1,1,1,  1,13, 0, 'h32, 'hE8, 4,3));
    tbl.push_back(mk(0,0,1,0, 13, 0, 5, 'h33, 'h81,  0,0,0,  0, 0, 0, 0,    0,    5,3));
    tbl.push_back(mk(0,0,1,0, 13, 0, 5, 'h33, 'h81,  1,1,1, 13, 0, 5, 'h33, 'h81, 5,3));

    // reset state before any clock edge
    #1;
    check_all_zero("reset");
    check("reset PCWrite", 32'(pcw), 32'h1);
    check("reset IFIDWrite", 32'(ifidw), 32'h1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // asynchronous reset between edges with a valid instruction in EX
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("async_rst PCWrite", 32'(pcw), 32'h1);
    hold = 1'b1;
    flush = 1'b1;
    #1;
    check("rst_hold PCWrite", 32'(pcw), 32'h0);
    check("rst_hold IFIDWrite", 32'(ifidw), 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge EXValid", 32'(ex_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // release mid-hold: one held edge, then a plain load must go through
    apply(mk(1,0,1,1, 2,3,4, 'h44, 'h81,  0,0,0, 0,0,0, 0,    0,    0,0), "post_rst_hold");
    apply(mk(0,0,1,1, 2,3,4, 'h44, 'h81,  1,1,1, 2,3,4, 'h44, 'h81, 0,0), "post_rst_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of bubble counter.
REQ-002 SHALL have clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have Hold_i  in  1  global freeze from memory system.
REQ-005 SHALL have Flush_i  in  1  branch taken in ID; squash the instruction in ID.
REQ-006 SHALL have IDValid_i  in  1  ID holds a real instruction.
REQ-007 SHALL have IDRegRs_i, IDRegRt_i, IDRegRd_i  in  5 each  ID register specifiers.
REQ-008 SHALL have IDUsesRt_i  in  1  ID instruction reads Rt as a source.
REQ-009 SHALL have IDData1_i, IDData2_i, IDImm_i  in  32 each  register-file reads and sign-extended immediate.
REQ-010 SHALL have IDCtrl_i  in  8  {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}.
REQ-011 SHALL have EXRegRs_o, EXRegRt_o, EXRegRd_o  out  5 each  registered specifiers consumed by forwarding logic.
REQ-012 SHALL have EXData1_o, EXData2_o, EXImm_o  out  32 each; EXCtrl_o  out  8; EXValid_o  out  1.
REQ-013 SHALL have PCWrite_o, IFIDWrite_o  out  1 each  upstream enables; BubbleCnt_o  out  CNT_W  bubbles inserted.

Function
REQ-014 SHALL detect load-use: LoadUse = EXValid_o & EXCtrl_o[MemRead] & EXRegRt_o!=0 & IDValid_i & (EXRegRt_o==IDRegRs_i | (IDUsesRt_i & EXRegRt_o==IDRegRt_i)).
REQ-015 SHALL drive PCWrite_o = IFIDWrite_o = ~(Hold_i | LoadUse), combinationally, same cycle.
REQ-016 SHALL apply per-edge priority: Hold > Flush(incl. pending) > LoadUse > normal load.
REQ-017 Hold_i=1 SHALL keep every EX register unchanged and BubbleCnt_o unchanged.
REQ-018 Flush_i=1 with Hold_i=0 SHALL load a bubble: EXValid_o=0, EXCtrl_o=0, specifiers 0, data don't-care.
REQ-019 Flush_i=1 with Hold_i=1 SHALL set a FlushPend flag; first edge with Hold_i=0 SHALL load a bubble and clear FlushPend.
REQ-020 LoadUse with no Hold/flush SHALL load a bubble and increment BubbleCnt_o by 1.
REQ-021 Normal load SHALL copy all ID inputs to EX outputs, EXValid_o=IDValid_i, one-cycle latency.
REQ-022 EXCtrl_o SHALL be forced to 0 whenever EXValid_o=0.
REQ-023 BubbleCnt_o SHALL saturate at 2^CNT_W-1, no wrap.
REQ-024 Flush bubbles SHALL NOT increment BubbleCnt_o.
REQ-025 SHALL be a two-state control FSM: RUN (FlushPend=0), PEND (FlushPend=1); RUN->PEND on Flush_i&Hold_i; PEND->RUN on ~Hold_i; Flush_i during PEND stays PEND.
REQ-026 LoadUse SHALL re-evaluate after the bubble; bubble makes EXValid_o=0 so stall lasts exactly one cycle per load.

Reset
REQ-027 rst_i=0 SHALL immediately clear all EX outputs, EXValid_o, FlushPend, BubbleCnt_o to 0, independent of clk_i.
REQ-028 During reset PCWrite_o and IFIDWrite_o SHALL be 1 unless Hold_i=1.
REQ-029 Reset release mid-Hold SHALL leave FSM in RUN with EX holding the bubble.

Structure
REQ-030 Shared package SHALL hold control-bit index constants (CTRL_REGWRITE..CTRL_ALUOP) and the 8-bit control width.
REQ-031 Hazard compare SHALL be one sub-module, load_use_detect, purely combinational; registers and FSM stay in id_ex_stage.

Verification
REQ-032 Normal: ID Rs=3,Rt=4,Data1=0x11,ctrl=0x81 -> next edge EXRegRs_o=3, EXData1_o=0x11, EXCtrl_o=0x81, EXValid_o=1.
REQ-033 Load-use: EX lw Rt=5 valid, ID Rs=5 -> PCWrite_o=0 same cycle; next edge EXValid_o=0, BubbleCnt_o=1; following cycle PCWrite_o=1.
REQ-034 Rt=0 / IDUsesRt_i=0: EX lw Rt=0 with ID Rs=0, or ID Rt match with IDUsesRt_i=0 -> no stall, count 0.
REQ-035 Flush under hold: Flush_i=1 with Hold_i=1 for 3 cycles -> EX unchanged; first edge after Hold_i=0 -> EXValid_o=0, FSM RUN.
REQ-036 Saturation: CNT_W=2, 5 load-use events -> BubbleCnt_o stops at 3.
REQ-037 Async reset: assert rst_i=0 between edges mid-stream -> all outputs 0 before next clk_i edge.
